// File: rtl/cpu_rd_ctl_pkg.sv
// Shared VGA memory-path constants, CPU read state encoding and hit-tag type.
package cpu_rd_ctl_pkg;

    localparam int unsigned ADDR_W       = 20;
    localparam int unsigned MEM_ADDR_LSB = 3;
    localparam int unsigned MEM_ADDR_MSB = 22;
    localparam int unsigned MEM_WORD_W   = MEM_ADDR_MSB - MEM_ADDR_LSB + 1;
    localparam int unsigned WIN_ADDR_W   = 18;
    localparam int unsigned DATA_W       = 32;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WDRAIN = 3'd1,
        ST_ARB    = 3'd2,
        ST_MEM    = 3'd3,
        ST_DATA   = 3'd4,
        ST_DONE   = 3'd5
    } cpurd_state_e;

    // Tag of the last word captured from memory, used by the read-hit path
    typedef struct packed {
        logic                  vld;
        logic [WIN_ADDR_W-1:0] addr;
    } rd_tag_t;

endpackage

// File: rtl/cpu_rd_ctl_if.sv
// Graphics / arbiter / memory-controller signals seen by the CPU read controller.
interface cpu_rd_ctl_if;
    import cpu_rd_ctl_pkg::*;

    logic                  g_memrd;
    logic                  g_memwr;
    logic [ADDR_W-1:0]     val_mrdwr_addr;
    logic                  ff_wr_pend;
    logic                  cpu_rd_gnt;
    logic                  crt_req;
    logic                  svga_ack;
    logic                  m_rd_dval;
    logic [DATA_W-1:0]     m_rd_data;
    logic                  cpu_rd_req;
    logic                  cpu_rd_svga_req;
    logic [MEM_WORD_W-1:0] cpurd_mem_addr;
    logic                  cpu_arb_rd;
    logic                  cpu_rd_busy;
    logic [DATA_W-1:0]     cpurd_data_out;
    logic                  cpurd_data_rdy;

    modport slave (
        input  g_memrd, g_memwr, val_mrdwr_addr, ff_wr_pend, cpu_rd_gnt,
               crt_req, svga_ack, m_rd_dval, m_rd_data,
        output cpu_rd_req, cpu_rd_svga_req, cpurd_mem_addr, cpu_arb_rd,
               cpu_rd_busy, cpurd_data_out, cpurd_data_rdy
    );

    modport master (
        output g_memrd, g_memwr, val_mrdwr_addr, ff_wr_pend, cpu_rd_gnt,
               crt_req, svga_ack, m_rd_dval, m_rd_data,
        input  cpu_rd_req, cpu_rd_svga_req, cpurd_mem_addr, cpu_arb_rd,
               cpu_rd_busy, cpurd_data_out, cpurd_data_rdy
    );

endinterface

// File: rtl/cpu_rd_ctl_sm_cpurd.sv
// CPU read state machine: write-drain ordering, arbitration, memory request and
// busy/ready signalling. Address and data latches live in the parent.
module cpu_rd_ctl_sm_cpurd
    import cpu_rd_ctl_pkg::*;
(
    input  logic mem_clk,
    input  logic hreset_n,
    input  logic g_memrd,
    input  logic g_memwr,
    input  logic ff_wr_pend,
    input  logic cpu_rd_gnt,
    input  logic crt_req,
    input  logic svga_ack,
    input  logic m_rd_dval,
    input  logic hit_c,
    output logic cpu_rd_req,
    output logic cpu_rd_svga_req,
    output logic cpu_arb_rd,
    output logic cpu_rd_busy,
    output logic cpurd_data_rdy,
    output logic accept_c,
    output logic capture_c
);

    cpurd_state_e state, state_nxt;
    logic         req_nxt, svga_nxt, arb_nxt, busy_nxt, rdy_nxt;

    // Next state, latch strobes and next registered outputs
    always_comb begin
        state_nxt = state;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        case (state)
            ST_IDLE: begin
                if (g_memrd) begin
                    accept_c = 1'b1;
                    if (hit_c)
                        state_nxt = ST_DONE;
                    else if (ff_wr_pend || g_memwr)
                        state_nxt = ST_WDRAIN;
                    else
                        state_nxt = ST_ARB;
                end
            end
            ST_WDRAIN: if (!ff_wr_pend && !g_memwr) state_nxt = ST_ARB;
            ST_ARB:    if (cpu_rd_gnt && !crt_req)  state_nxt = ST_MEM;
            ST_MEM:    if (svga_ack)                state_nxt = ST_DATA;
            ST_DATA: begin
                // data valid alongside ack is never seen here: MEM ignores it
                if (m_rd_dval) begin
                    capture_c = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase

        req_nxt  = (state_nxt == ST_ARB) || (state_nxt == ST_MEM);
        svga_nxt = (state_nxt == ST_MEM);
        arb_nxt  = (state_nxt == ST_MEM) || (state_nxt == ST_DATA);
        busy_nxt = (state_nxt != ST_IDLE);
        rdy_nxt  = (state == ST_DONE);
    end

    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            state           <= ST_IDLE;
            cpu_rd_req      <= 1'b0;
            cpu_rd_svga_req <= 1'b0;
            cpu_arb_rd      <= 1'b0;
            cpu_rd_busy     <= 1'b0;
            cpurd_data_rdy  <= 1'b0;
        end else begin
            state           <= state_nxt;
            cpu_rd_req      <= req_nxt;
            cpu_rd_svga_req <= svga_nxt;
            cpu_arb_rd      <= arb_nxt;
            cpu_rd_busy     <= busy_nxt;
            cpurd_data_rdy  <= rdy_nxt;
        end
    end

endmodule

// File: rtl/cpu_rd_ctl.sv
// CPU read controller for the VGA memory path. Optional read-hit shortcut
// on the last captured word is enabled by defining CPU_RD_HIT_EN.
module cpu_rd_ctl
    import cpu_rd_ctl_pkg::*;
(
    input  logic        mem_clk,
    input  logic        hreset_n,
    cpu_rd_ctl_if.slave bus
);

    logic [WIN_ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0]     data_q;
    logic                  accept_c;
    logic                  capture_c;
    logic                  hit_c;
    logic                  addr_hi_unused;

    cpu_rd_ctl_sm_cpurd u_sm (
        .mem_clk         (mem_clk),
        .hreset_n        (hreset_n),
        .g_memrd         (bus.g_memrd),
        .g_memwr         (bus.g_memwr),
        .ff_wr_pend      (bus.ff_wr_pend),
        .cpu_rd_gnt      (bus.cpu_rd_gnt),
        .crt_req         (bus.crt_req),
        .svga_ack        (bus.svga_ack),
        .m_rd_dval       (bus.m_rd_dval),
        .hit_c           (hit_c),
        .cpu_rd_req      (bus.cpu_rd_req),
        .cpu_rd_svga_req (bus.cpu_rd_svga_req),
        .cpu_arb_rd      (bus.cpu_arb_rd),
        .cpu_rd_busy     (bus.cpu_rd_busy),
        .cpurd_data_rdy  (bus.cpurd_data_rdy),
        .accept_c        (accept_c),
        .capture_c       (capture_c)
    );

    // Address and read-word latches
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            addr_q <= '0;
            data_q <= '0;
        end else begin
            if (accept_c)
                addr_q <= bus.val_mrdwr_addr[WIN_ADDR_W-1:0];
            if (capture_c)
                data_q <= bus.m_rd_data;
        end
    end

    // Host address bits above the 256K-word window are dropped, as on the write path
    assign addr_hi_unused     = |bus.val_mrdwr_addr[ADDR_W-1:WIN_ADDR_W];
    assign bus.cpurd_mem_addr = MEM_WORD_W'(addr_q);
    assign bus.cpurd_data_out = data_q;

`ifdef CPU_RD_HIT_EN
    rd_tag_t tag_q;

    // Any host write may alias the cached word, so it always wins over a capture
    always_ff @(posedge mem_clk or negedge hreset_n) begin
        if (!hreset_n) begin
            tag_q <= '0;
        end else if (bus.g_memwr) begin
            tag_q.vld <= 1'b0;
        end else if (capture_c) begin
            tag_q.vld  <= 1'b1;
            tag_q.addr <= addr_q;
        end
    end

    assign hit_c = tag_q.vld && !bus.g_memwr &&
                   (bus.val_mrdwr_addr[WIN_ADDR_W-1:0] == tag_q.addr);
`else
    assign hit_c = 1'b0;
`endif

endmodule

// File: tb/tb_cpu_rd_ctl.sv
// Directed bench for cpu_rd_ctl: per-vector milestone model plus literal pins.
module tb_cpu_rd_ctl;

    localparam int NMAX = 32;
    localparam int BIG  = 10000;
    localparam int K_RD = 0, K_DRAIN = 1, K_GNT = 2, K_ACK = 3, K_DVAL = 4;
`ifdef CPU_RD_HIT_EN
    localparam bit HIT_EN = 1'b1;
`else
    localparam bit HIT_EN = 1'b0;
`endif

    logic mem_clk;
    logic hreset_n;

    cpu_rd_ctl_if bus();

    cpu_rd_ctl dut (
        .mem_clk  (mem_clk),
        .hreset_n (hreset_n),
        .bus      (bus)
    );

    initial mem_clk = 1'b0;
    always #5 mem_clk = ~mem_clk;

    logic        s_rd[NMAX], s_wr[NMAX], s_pend[NMAX], s_gnt[NMAX];
    logic        s_crt[NMAX], s_ack[NMAX], s_dval[NMAX];
    logic [19:0] s_addr[NMAX];
    logic [31:0] s_data[NMAX];

    logic        e_req[NMAX], e_svga[NMAX], e_arb[NMAX], e_busy[NMAX], e_rdy[NMAX];
    logic [31:0] e_dout[NMAX];
    logic [19:0] e_maddr[NMAX];

    int n_chk  = 0;
    int n_pass = 0;
    int idx    = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %h, expected %h", nm, cyc, act, exp);
    endtask

    // Cycle-by-cycle comparison against the model while a vector runs
    always @(negedge mem_clk) begin
        if (chk_en) begin
            chk("cpu_rd_req",      idx, 32'(bus.cpu_rd_req),      32'(e_req[idx]));
            chk("cpu_rd_svga_req", idx, 32'(bus.cpu_rd_svga_req), 32'(e_svga[idx]));
            chk("cpu_arb_rd",      idx, 32'(bus.cpu_arb_rd),      32'(e_arb[idx]));
            chk("cpu_rd_busy",     idx, 32'(bus.cpu_rd_busy),     32'(e_busy[idx]));
            chk("cpurd_data_rdy",  idx, 32'(bus.cpurd_data_rdy),  32'(e_rdy[idx]));
            chk("cpurd_data_out",  idx, bus.cpurd_data_out,       e_dout[idx]);
            chk("cpurd_mem_addr",  idx, 32'(bus.cpurd_mem_addr),  32'(e_maddr[idx]));
        end
    end

    task automatic drive_idle();
        bus.g_memrd = 1'b0; bus.g_memwr = 1'b0; bus.val_mrdwr_addr = '0;
        bus.ff_wr_pend = 1'b0; bus.cpu_rd_gnt = 1'b0; bus.crt_req = 1'b0;
        bus.svga_ack = 1'b0; bus.m_rd_dval = 1'b0; bus.m_rd_data = '0;
    endtask

    task automatic clear_vec();
        for (int c = 0; c < NMAX; c++) begin
            s_rd[c] = 0; s_wr[c] = 0; s_pend[c] = 0; s_gnt[c] = 0;
            s_crt[c] = 0; s_ack[c] = 0; s_dval[c] = 0; s_addr[c] = '0; s_data[c] = '0;
        end
    endtask

    task automatic do_reset();
        @(negedge mem_clk);
        hreset_n = 1'b0;
        drive_idle();
        @(negedge mem_clk);
        @(negedge mem_clk);
        hreset_n = 1'b1;
    endtask

    function automatic int find_ev(input int kind, input int from, input int len);
        for (int c = from; c < len; c++) begin
            case (kind)
                K_RD:    if (s_rd[c]) return c;
                K_DRAIN: if (!s_pend[c] && !s_wr[c]) return c;
                K_GNT:   if (s_gnt[c] && !s_crt[c]) return c;
                K_ACK:   if (s_ack[c]) return c;
                K_DVAL:  if (s_dval[c]) return c;
                default: ;
            endcase
        end
        return BIG;
    endfunction

    // Milestone model: find accept, drain end, grant, ack and data cycles for each
    // accepted read and derive every output's active window from them.
    task automatic build_model(input int len);
        int r, as_c, g, a, v, free, last_cap;
        logic [17:0] tag;
        bit hit;
        for (int c = 0; c < NMAX; c++) begin
            e_req[c] = 0; e_svga[c] = 0; e_arb[c] = 0; e_busy[c] = 0; e_rdy[c] = 0;
            e_dout[c] = '0; e_maddr[c] = '0;
        end
        free = 0; last_cap = -1; tag = '0;
        r = find_ev(K_RD, free, len);
        while (r < len) begin
            for (int c = r + 1; c < NMAX; c++) e_maddr[c] = {2'b00, s_addr[r][17:0]};
            hit = HIT_EN && (last_cap >= 0) && (tag == s_addr[r][17:0]) && !s_wr[r];
            for (int c = last_cap; c < r && hit; c++) if (s_wr[c]) hit = 1'b0;
            if (hit) begin
                if (r + 1 < NMAX) e_busy[r+1] = 1'b1;
                if (r + 2 < NMAX) e_rdy[r+2] = 1'b1;
                free = r + 2;
            end else begin
                as_c = (s_pend[r] || s_wr[r]) ? find_ev(K_DRAIN, r + 1, len) + 1 : r + 1;
                g = find_ev(K_GNT, as_c, len);
                a = find_ev(K_ACK, g + 1, len);
                v = find_ev(K_DVAL, a + 1, len);
                for (int c = 0; c < NMAX; c++) begin
                    if (c >= as_c && c <= a) e_req[c]  = 1'b1;
                    if (c > g && c <= a)     e_svga[c] = 1'b1;
                    if (c > g && c <= v)     e_arb[c]  = 1'b1;
                    if (c > r && c <= v + 1) e_busy[c] = 1'b1;
                    if (c == v + 2)          e_rdy[c]  = 1'b1;
                    if (v < len && c > v)    e_dout[c] = s_data[v];
                end
                last_cap = v; tag = s_addr[r][17:0]; free = v + 2;
            end
            r = find_ev(K_RD, free, len);
        end
    endtask

    task automatic run_vec(input int len);
        for (int c = 0; c < len; c++) begin
            @(posedge mem_clk);
            #1;
            bus.g_memrd = s_rd[c]; bus.g_memwr = s_wr[c]; bus.val_mrdwr_addr = s_addr[c];
            bus.ff_wr_pend = s_pend[c]; bus.cpu_rd_gnt = s_gnt[c]; bus.crt_req = s_crt[c];
            bus.svga_ack = s_ack[c]; bus.m_rd_dval = s_dval[c]; bus.m_rd_data = s_data[c];
            idx = c;
            chk_en = 1'b1;
        end
        @(posedge mem_clk);
        #1;
        chk_en = 1'b0;
        drive_idle();
    endtask

    initial begin
        hreset_n = 1'b0;
        drive_idle();
        @(negedge mem_clk);
        chk("reset cpu_rd_req",     0, 32'(bus.cpu_rd_req),      32'd0);
        chk("reset cpu_rd_svga_req",0, 32'(bus.cpu_rd_svga_req), 32'd0);
        chk("reset cpu_arb_rd",     0, 32'(bus.cpu_arb_rd),      32'd0);
        chk("reset cpu_rd_busy",    0, 32'(bus.cpu_rd_busy),     32'd0);
        chk("reset cpurd_data_rdy", 0, 32'(bus.cpurd_data_rdy),  32'd0);
        chk("reset cpurd_data_out", 0, bus.cpurd_data_out,       32'd0);
        chk("reset cpurd_mem_addr", 0, 32'(bus.cpurd_mem_addr),  32'd0);

        // Best case: rdy in cycle 5
        do_reset(); clear_vec();
        s_rd[0] = 1; s_addr[0] = 20'h00123; s_gnt[1] = 1; s_ack[2] = 1;
        s_dval[3] = 1; s_data[3] = 32'hA5A5_5A5A;
        build_model(8);
        chk("model best rdy@5",  5, 32'(e_rdy[5]),  32'd1);
        chk("model best rdy@4",  4, 32'(e_rdy[4]),  32'd0);
        chk("model best data@5", 5, e_dout[5],      32'hA5A5_5A5A);
        chk("model best addr@2", 2, 32'(e_maddr[2]), 32'h00123);
        chk("model best busy@5", 5, 32'(e_busy[5]), 32'd0);
        run_vec(8);

        // Write FIFO drain; grant held high throughout; stray dval while draining
        do_reset(); clear_vec();
        s_rd[0] = 1; s_addr[0] = 20'hCA5C3;
        for (int c = 0; c < 6; c++) s_pend[c] = 1;
        for (int c = 0; c < 18; c++) s_gnt[c] = 1;
        s_dval[5] = 1; s_data[5] = 32'hDEAD_0005;
        s_ack[10] = 1; s_dval[13] = 1; s_data[13] = 32'h1234_5678;
        build_model(18);
        chk("model drain req@6",  6, 32'(e_req[6]),   32'd0);
        chk("model drain req@7",  7, 32'(e_req[7]),   32'd1);
        chk("model drain rdy@15", 15, 32'(e_rdy[15]), 32'd1);
        chk("model drain addr@1", 1, 32'(e_maddr[1]), 32'h0A5C3);
        run_vec(18);

        // Same-cycle write, CRT contention, dval with ack is not data
        do_reset(); clear_vec();
        s_rd[0] = 1; s_wr[0] = 1; s_addr[0] = 20'h3FFFF;
        for (int c = 2; c < 6; c++) s_gnt[c] = 1;
        for (int c = 2; c < 5; c++) s_crt[c] = 1;
        s_ack[6] = 1; s_dval[6] = 1; s_data[6] = 32'hDEAD_BEEF;
        s_dval[7] = 1; s_data[7] = 32'h0F0F_F0F0;
        build_model(12);
        chk("model crt svga@5", 5, 32'(e_svga[5]), 32'd0);
        chk("model crt svga@6", 6, 32'(e_svga[6]), 32'd1);
        chk("model crt req@4",  4, 32'(e_req[4]),  32'd1);
        chk("model crt rdy@9",  9, 32'(e_rdy[9]),  32'd1);
        run_vec(12);

        // Strobes while busy ignored, then back-to-back read
        do_reset(); clear_vec();
        s_rd[0] = 1; s_addr[0] = 20'h00456; s_gnt[1] = 1; s_ack[3] = 1;
        s_rd[5] = 1; s_addr[5] = 20'h0FFFF; s_rd[8] = 1; s_addr[8] = 20'h0FFFF;
        s_dval[7] = 1; s_data[7] = 32'h600D_F00D;
        s_rd[9] = 1; s_addr[9] = 20'h00777; s_gnt[10] = 1; s_ack[11] = 1;
        s_dval[12] = 1; s_data[12] = 32'h0000_0001;
        build_model(17);
        chk("model ign addr@8",  8, 32'(e_maddr[8]), 32'h00456);
        chk("model ign rdy@9",   9, 32'(e_rdy[9]),   32'd1);
        chk("model b2b rdy@14", 14, 32'(e_rdy[14]),  32'd1);
        chk("model b2b data@14",14, e_dout[14],      32'h0000_0001);
        run_vec(17);

        // Repeat read of the same word, write, then read again
        do_reset(); clear_vec();
        for (int c = 0; c < 22; c++) begin
            s_gnt[c] = 1; s_ack[c] = 1; s_dval[c] = 1; s_data[c] = 32'hCAFE_0000 | 32'(c);
        end
        s_rd[0] = 1; s_addr[0] = 20'h00040;
        s_rd[6] = 1; s_addr[6] = 20'h00040;
        s_wr[12] = 1;
        s_rd[14] = 1; s_addr[14] = 20'h00040;
        build_model(22);
        if (HIT_EN) begin
            chk("model hit rdy@8", 8, 32'(e_rdy[8]), 32'd1);
            chk("model hit req@7", 7, 32'(e_req[7]), 32'd0);
        end else begin
            chk("model nohit rdy@11", 11, 32'(e_rdy[11]), 32'd1);
        end
        chk("model post-wr req@15", 15, 32'(e_req[15]), 32'd1);
        chk("model post-wr data@19", 19, e_dout[19], 32'hCAFE_0011);
        run_vec(22);

        // Asynchronous reset while the second read sits in MEM
        do_reset(); clear_vec();
        s_rd[0] = 1; s_addr[0] = 20'h11111; s_gnt[1] = 1; s_ack[2] = 1;
        s_dval[3] = 1; s_data[3] = 32'h1111_2222;
        s_rd[6] = 1; s_addr[6] = 20'h00ABC; s_gnt[7] = 1;
        build_model(10);
        run_vec(10);
        #1;
        chk("pre-reset svga_req", 10, 32'(bus.cpu_rd_svga_req), 32'd1);
        chk("pre-reset arb_rd",   10, 32'(bus.cpu_arb_rd),      32'd1);
        chk("pre-reset data_out", 10, bus.cpurd_data_out,       32'h1111_2222);
        hreset_n = 1'b0;
        #1;
        chk("async rst cpu_rd_req",      10, 32'(bus.cpu_rd_req),      32'd0);
        chk("async rst cpu_rd_svga_req", 10, 32'(bus.cpu_rd_svga_req), 32'd0);
        chk("async rst cpu_arb_rd",      10, 32'(bus.cpu_arb_rd),      32'd0);
        chk("async rst cpu_rd_busy",     10, 32'(bus.cpu_rd_busy),     32'd0);
        chk("async rst cpurd_data_out",  10, bus.cpurd_data_out,       32'd0);
        chk("async rst cpurd_mem_addr",  10, 32'(bus.cpurd_mem_addr),  32'd0);
        @(negedge mem_clk);
        hreset_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge mem_clk);
            #1;
            bus.cpu_rd_gnt = 1'b1;
            bus.svga_ack   = (k == 0);
            bus.m_rd_dval  = (k == 2);
            bus.m_rd_data  = 32'hBAD0_0BAD;
            @(negedge mem_clk);
            chk("post-rst data_rdy", 11 + k, 32'(bus.cpurd_data_rdy), 32'd0);
            chk("post-rst busy",     11 + k, 32'(bus.cpu_rd_busy),    32'd0);
            chk("post-rst req",      11 + k, 32'(bus.cpu_rd_req),     32'd0);
            chk("post-rst data_out", 11 + k, bus.cpurd_data_out,      32'd0);
        end
        drive_idle();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
